// File: rtl/kbseq_pkg.sv
// Shared types and constants for the PS/2 autotype key sequencer.
// Event payload layout: [9] pressed, [8] extended, [7:0] scancode.
package kbseq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_DN,
        KEY_DN,
        HOLD,
        KEY_UP,
        SHIFT_UP,
        GAP
    } seq_state_e;

    localparam logic [7:0] SC_LSHIFT = 8'h12;

    localparam int PS2_TGL = 10;
    localparam int PS2_PRS = 9;
    localparam int PS2_EXT = 8;

    function automatic logic [9:0] build_evt(input logic       pressed,
                                             input logic       ext,
                                             input logic [7:0] code);
        logic [9:0] evt;
        evt          = '0;
        evt[PS2_PRS] = pressed;
        evt[PS2_EXT] = ext;
        evt[7:0]     = code;
        return evt;
    endfunction

endpackage

// File: rtl/ps2_evt_emitter.sv
// Owns the keyboard event port: forwards live HPS events with priority and
// grants the autotype FSM a slot only in cycles with no live event.
module ps2_evt_emitter
    import kbseq_pkg::*;
(
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] live_key_i,
    input  logic        req_i,
    input  logic [9:0]  evt_i,
    output logic        grant_o,
    output logic [10:0] key_o
);

    logic        armed_q;
    logic        prev_live_q;
    logic [10:0] key_q;
    logic        live_evt;

    // Until the first edge the toggle history is unknown, so a mismatch
    // against the reset value must not be treated as a keystroke.
    assign live_evt = armed_q && (live_key_i[PS2_TGL] != prev_live_q);
    assign grant_o  = armed_q && req_i && !live_evt;
    assign key_o    = key_q;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            armed_q     <= 1'b0;
            prev_live_q <= 1'b0;
            key_q       <= 11'h000;
        end else begin
            armed_q     <= 1'b1;
            prev_live_q <= live_key_i[PS2_TGL];
            if (live_evt) begin
                key_q <= {~key_q[PS2_TGL], live_key_i[9:0]};
            end else if (grant_o) begin
                key_q <= {~key_q[PS2_TGL], evt_i};
            end
        end
    end

endmodule

// File: rtl/ps2_key_sequencer.sv
// Turns autotype characters into timed press/hold/release sequences and
// merges them with live PS/2 traffic onto the single keyboard event port.
module ps2_key_sequencer
    import kbseq_pkg::*;
#(
    parameter int HOLD_CYCLES = 500000,
    parameter int GAP_CYCLES  = 500000,
    parameter int CNT_W       = 24
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key_in,
    input  logic        at_valid,
    output logic        at_ready,
    input  logic [7:0]  at_code,
    input  logic        at_ext,
    input  logic        at_shift,
    input  logic        at_abort,
    output logic [10:0] ps2_key_out,
    output logic        busy
);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             key_dn_q, key_dn_d;
    logic             shift_dn_q, shift_dn_d;
    logic [7:0]       code_q, code_d;
    logic             ext_q, ext_d;
    logic             at_ready_q;
    logic             busy_q;

    logic             req;
    logic [9:0]       evt;
    logic             grant;

    ps2_evt_emitter u_emitter (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .live_key_i (ps2_key_in),
        .req_i      (req),
        .evt_i      (evt),
        .grant_o    (grant),
        .key_o      (ps2_key_out)
    );

    // Emit states hold their request until the emitter grants a free cycle.
    // Abort is resolved against the held-key flags after this cycle's grant,
    // so a press that just went out is always followed by its release.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        key_dn_d   = key_dn_q;
        shift_dn_d = shift_dn_q;
        code_d     = code_q;
        ext_d      = ext_q;
        req        = 1'b0;
        evt        = '0;

        case (state_q)
            IDLE: begin
                if (at_valid && at_ready_q) begin
                    code_d  = at_code;
                    ext_d   = at_ext;
                    state_d = at_shift ? SHIFT_DN : KEY_DN;
                end
            end
            SHIFT_DN: begin
                req = 1'b1;
                evt = build_evt(1'b1, 1'b0, SC_LSHIFT);
                if (grant) begin
                    shift_dn_d = 1'b1;
                    state_d    = KEY_DN;
                end
            end
            KEY_DN: begin
                req = 1'b1;
                evt = build_evt(1'b1, ext_q, code_q);
                if (grant) begin
                    key_dn_d = 1'b1;
                    timer_d  = HOLD_LOAD;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (timer_q == '0) begin
                    state_d = KEY_UP;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            KEY_UP: begin
                req = 1'b1;
                evt = build_evt(1'b0, ext_q, code_q);
                if (grant) begin
                    key_dn_d = 1'b0;
                    if (shift_dn_q) begin
                        state_d = SHIFT_UP;
                    end else begin
                        timer_d = GAP_LOAD;
                        state_d = GAP;
                    end
                end
            end
            SHIFT_UP: begin
                req = 1'b1;
                evt = build_evt(1'b0, 1'b0, SC_LSHIFT);
                if (grant) begin
                    shift_dn_d = 1'b0;
                    timer_d    = GAP_LOAD;
                    state_d    = GAP;
                end
            end
            GAP: begin
                if (timer_q == '0) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (at_abort && (state_q != IDLE)) begin
            if (key_dn_d) begin
                state_d = KEY_UP;
            end else if (shift_dn_d) begin
                state_d = SHIFT_UP;
            end else begin
                state_d = IDLE;
            end
        end
    end

    // The emitter arms on the first edge out of reset, so after any edge
    // "armed and idle" reduces to the next state being IDLE.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            key_dn_q   <= 1'b0;
            shift_dn_q <= 1'b0;
            code_q     <= 8'h00;
            ext_q      <= 1'b0;
            at_ready_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            key_dn_q   <= key_dn_d;
            shift_dn_q <= shift_dn_d;
            code_q     <= code_d;
            ext_q      <= ext_d;
            at_ready_q <= (state_d == IDLE);
            busy_q     <= (state_d != IDLE);
        end
    end

    assign at_ready = at_ready_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Scoreboard bench for ps2_key_sequencer with short hold/gap timers.
// Stimulus pushes expected payloads; a monitor pops them on every toggle.
module tb_ps2_key_sequencer;

    localparam int HOLD = 4;
    localparam int GAPC = 3;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [10:0] ps2_key_in;
    logic        at_valid;
    logic        at_ready;
    logic [7:0]  at_code;
    logic        at_ext;
    logic        at_shift;
    logic        at_abort;
    logic [10:0] ps2_key_out;
    logic        busy;

    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    int          evCount     = 0;
    int          evCyc[$];
    logic [9:0]  expQ[$];
    logic        lastTgl     = 1'b0;

    ps2_key_sequencer #(
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAPC),
        .CNT_W       (8)
    ) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .ps2_key_in  (ps2_key_in),
        .at_valid    (at_valid),
        .at_ready    (at_ready),
        .at_code     (at_code),
        .at_ext      (at_ext),
        .at_shift    (at_shift),
        .at_abort    (at_abort),
        .ps2_key_out (ps2_key_out),
        .busy        (busy)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Every toggle of the event port must match the oldest expected payload.
    always @(negedge clk_sys) begin
        if (reset) begin
            lastTgl = ps2_key_out[10];
        end else if (ps2_key_out[10] != lastTgl) begin
            lastTgl = ps2_key_out[10];
            evCount++;
            evCyc.push_back(cyc);
            if (expQ.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_event: got %0h, none expected", ps2_key_out[9:0]);
            end else begin
                checkOutput("event_payload", 32'(ps2_key_out[9:0]), 32'(expQ.pop_front()));
            end
        end
    end

    task automatic tick();
        @(negedge clk_sys);
        #1;
    endtask

    function automatic logic [9:0] mk(input logic p, input logic e, input logic [7:0] c);
        return {p, e, c};
    endfunction

    task automatic applyStimulus(input logic [7:0] code, input logic ext, input logic shift);
        int n;
        n = 0;
        while (!at_ready && n < 200) begin
            tick();
            n++;
        end
        checkOutput("ready_before_send", 32'(at_ready), 32'd1);
        at_code  = code;
        at_ext   = ext;
        at_shift = shift;
        at_valid = 1'b1;
        if (shift) expQ.push_back(mk(1'b1, 1'b0, 8'h12));
        expQ.push_back(mk(1'b1, ext, code));
        expQ.push_back(mk(1'b0, ext, code));
        if (shift) expQ.push_back(mk(1'b0, 1'b0, 8'h12));
        tick();
        at_valid = 1'b0;
    endtask

    task automatic waitIdle(output int readyCyc);
        int n;
        n = 0;
        while (!(at_ready && !busy) && n < 500) begin
            tick();
            n++;
        end
        checkOutput("idle_reached", 32'(at_ready && !busy), 32'd1);
        readyCyc = cyc;
    endtask

    task automatic waitEvents(input int target);
        int n;
        n = 0;
        while (evCount < target && n < 500) begin
            tick();
            n++;
        end
        checkOutput("event_count_reached", 32'(evCount >= target), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base;
        int rdy;
        int n;

        reset      = 1'b1;
        ps2_key_in = 11'h400;
        at_valid   = 1'b0;
        at_code    = 8'h00;
        at_ext     = 1'b0;
        at_shift   = 1'b0;
        at_abort   = 1'b0;
        tick();
        tick();

        // Reset release with the live toggle already high: no spurious event.
        reset = 1'b0;
        checkOutput("reset_out", 32'(ps2_key_out), 32'h0);
        checkOutput("reset_ready", 32'(at_ready), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        tick();
        checkOutput("ready_after_arm", 32'(at_ready), 32'd1);
        for (int i = 0; i < 10; i++) tick();
        checkOutput("no_spurious_event", 32'(evCount), 32'd0);

        // Plain key: press, 4 HOLD cycles plus the KEY_UP cycle, release,
        // then 3 GAP cycles; a request while busy must be dropped.
        base = evCount;
        applyStimulus(8'h1C, 1'b0, 1'b0);
        checkOutput("busy_after_accept", 32'(busy), 32'd1);
        at_code  = 8'h33;
        at_valid = 1'b1;
        tick();
        at_valid = 1'b0;
        waitIdle(rdy);
        checkOutput("plain_event_count", 32'(evCount - base), 32'd2);
        checkOutput("hold_spacing", 32'(evCyc[base + 1] - evCyc[base]), 32'd5);
        checkOutput("gap_spacing", 32'(rdy - evCyc[base + 1]), 32'd3);

        // Shifted key: four events in shift-wrapped order.
        base = evCount;
        applyStimulus(8'h45, 1'b0, 1'b1);
        waitIdle(rdy);
        checkOutput("shift_event_count", 32'(evCount - base), 32'd4);

        // Live event colliding with the KEY_DN emission wins; autotype follows.
        base = evCount;
        expQ.push_back(mk(1'b1, 1'b0, 8'h29));
        applyStimulus(8'h1C, 1'b0, 1'b0);
        ps2_key_in = {~ps2_key_in[10], 1'b1, 1'b0, 8'h29};
        waitIdle(rdy);
        checkOutput("live_event_count", 32'(evCount - base), 32'd3);
        checkOutput("live_then_auto", 32'(evCyc[base + 1] - evCyc[base]), 32'd1);

        // Abort during HOLD: releases follow immediately, then the gap.
        base = evCount;
        applyStimulus(8'h45, 1'b0, 1'b1);
        waitEvents(base + 2);
        at_abort = 1'b1;
        tick();
        at_abort = 1'b0;
        waitIdle(rdy);
        checkOutput("abort_event_count", 32'(evCount - base), 32'd4);
        checkOutput("abort_release_spacing", 32'(evCyc[base + 2] - evCyc[base + 1]), 32'd2);
        checkOutput("abort_gap_spacing", 32'(rdy - evCyc[base + 3]), 32'd3);

        // Async reset mid-HOLD clears everything with no release events.
        base = evCount;
        expQ.push_back(mk(1'b1, 1'b0, 8'h1C));
        at_code  = 8'h1C;
        at_ext   = 1'b0;
        at_shift = 1'b0;
        n = 0;
        while (!at_ready && n < 200) begin
            tick();
            n++;
        end
        at_valid = 1'b1;
        tick();
        at_valid = 1'b0;
        waitEvents(base + 1);
        tick();
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midhold_reset_out", 32'(ps2_key_out), 32'h0);
        checkOutput("midhold_reset_busy", 32'(busy), 32'd0);
        checkOutput("midhold_reset_ready", 32'(at_ready), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        checkOutput("no_release_after_reset", 32'(evCount - base), 32'd1);
        base = evCount;
        applyStimulus(8'h1C, 1'b0, 1'b0);
        waitIdle(rdy);
        checkOutput("post_reset_event_count", 32'(evCount - base), 32'd2);

        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
